// File: rtl/axis_byte_packer.sv
// axis_byte_packer
// Packs RATIO consecutive DATA_WIDTH-bit AXI-Stream beats into one wide beat
// with a tkeep lane mask. A tlast beat closes the current word early, so a
// word never spans two packets. Lane 0 holds the first beat of a word.
// RATIO is expected to be 2, 4 or 8.
module axis_byte_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [DATA_WIDTH*RATIO-1:0]   m_axis_tdata,
  output logic [RATIO-1:0]              m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  localparam int                IDX_W    = $clog2(RATIO);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATIO - 1);

  // Accumulator: lanes 0..RATIO-2 only; the top lane is never stored because
  // the beat that fills it always completes the word on the same edge.
  logic [RATIO-2:0][DATA_WIDTH-1:0] r_lanes;
  logic [IDX_W-1:0]                 r_idx;

  logic [DATA_WIDTH*RATIO-1:0]      r_m_data;
  logic [RATIO-1:0]                 r_m_keep;
  logic                             r_m_last;
  logic                             r_m_valid;

  logic                             w_s_ready;
  logic                             w_s_xfer;
  logic                             w_complete;
  logic [DATA_WIDTH*RATIO-1:0]      w_word;
  logic [RATIO-1:0]                 w_keep;

  // Input may advance when no word is pending or the pending one drains now.
  assign w_s_ready  = reset & (~r_m_valid | m_axis_tready);
  assign w_s_xfer   = s_axis_tvalid & w_s_ready;
  assign w_complete = w_s_xfer & ((r_idx == LAST_IDX) | s_axis_tlast);

  // Assemble the outgoing word: stored lanes below idx, incoming beat at idx,
  // zeros above idx; tkeep covers lanes 0..idx.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    w_word = '0;
    w_keep = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (IDX_W'(i) < r_idx) w_word[i*DATA_WIDTH +: DATA_WIDTH] = r_lanes[i];
    end
    for (int i = 0; i < RATIO; i++) begin
      if (IDX_W'(i) == r_idx) w_word[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
      w_keep[i] = (IDX_W'(i) <= r_idx);
    end
  end

  // Accumulator and lane index: store non-completing beats, wrap on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the lane storage is reset along with idx; it is only a few
      // registers, and it guarantees nothing from before reset is ever visible.
      r_lanes <= '0;
      r_idx   <= '0;
    end else if (w_s_xfer) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < RATIO - 1; i++) begin
        if (!w_complete && (r_idx == IDX_W'(i))) r_lanes[i] <= s_axis_tdata;
      end
      r_idx <= w_complete ? '0 : r_idx + 1'b1;
    end
  end

  // Output register: load a completed word, otherwise drop valid once drained.
  // A load can only happen when the slot is free or draining, so the held
  // word stays stable under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_complete) begin
      r_m_data  <= w_word;
      r_m_keep  <= w_keep;
      r_m_last  <= s_axis_tlast;
      r_m_valid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tvalid = r_m_valid;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Testbench for axis_byte_packer (DATA_WIDTH = 8, RATIO = 4).
// Directed table of beats with expected outputs, a reset-mid-packet sequence,
// and a randomized stream with backpressure checked against a queue-based
// reference model that packs accepted bytes into words.
module tb_axis_byte_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int N_RAND = 300;

  logic            clk;
  logic            reset;
  logic [DW-1:0]   s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [DW*R-1:0] m_tdata;
  logic [R-1:0]    m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;

  int tests  = 0;
  int failed = 0;

  axis_byte_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [DW*R-1:0] data;
    logic [R-1:0]    keep;
    logic            last;
  } word_t;

  word_t          exp_q[$];
  logic [DW-1:0]  part_q[$];

  // Sampled at negedge: the handshakes seen here take effect at the next posedge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      part_q.delete();
    end else begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 1'b1, 1'b0);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("sb_data", m_tdata, w.data);
          check("sb_keep", m_tkeep, w.keep);
          check("sb_last", m_tlast, w.last);
        end
      end
      if (s_tvalid && s_tready) begin
        part_q.push_back(s_tdata);
        if (part_q.size() == R || s_tlast) begin
          word_t w;
          w.data = '0;
          for (int i = 0; i < part_q.size(); i++) w.data[i*DW +: DW] = part_q[i];
          w.keep = R'((1 << part_q.size()) - 1);
          w.last = s_tlast;
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [DW-1:0]   din;
    logic            lin;
    logic            exp_valid;
    logic [DW*R-1:0] exp_data;
    logic [R-1:0]    exp_keep;
    logic            exp_last;
  } vec_t;

  vec_t vecs[15];

  // Present one beat (m_tready held 1), let it be accepted, sample after the edge.
  task automatic send(input logic [DW-1:0] d, input logic l, input string tag);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    check({tag, "_s_ready"}, s_tready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic            acc;
    int              sent;
    int              cyc;
    int              stall_left;
    logic            stall_done;
    logic [DW*R-1:0] held_data;
    logic [R-1:0]    held_keep;
    logic            held_last;

    vecs[0]  = '{8'h01, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[1]  = '{8'h02, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[2]  = '{8'h03, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[3]  = '{8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0};
    vecs[4]  = '{8'h05, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[5]  = '{8'h06, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[6]  = '{8'h07, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[7]  = '{8'h08, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b1};
    vecs[8]  = '{8'h11, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[9]  = '{8'h12, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[10] = '{8'h13, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[11] = '{8'h14, 1'b0, 1'b1, 32'h14131211, 4'hF, 1'b0};
    vecs[12] = '{8'h15, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[13] = '{8'h16, 1'b1, 1'b1, 32'h00001615, 4'h3, 1'b1};
    vecs[14] = '{8'hAA, 1'b1, 1'b1, 32'h000000AA, 4'h1, 1'b1};

    // ---- reset held 3 cycles with s_tvalid asserted ----
    reset    = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h5A;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_tvalid, 1'b0);
    check("rst_m_data",  m_tdata,  '0);
    check("rst_m_keep",  m_tkeep,  '0);
    check("rst_m_last",  m_tlast,  1'b0);
    check("rst_s_ready", s_tready, 1'b0);
    reset    = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_s_ready", s_tready, 1'b1);
    check("post_rst_m_valid", m_tvalid, 1'b0);

    // ---- table-driven directed beats ----
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].din, vecs[i].lin, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_valid", i), m_tvalid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), m_tdata, vecs[i].exp_data);
        check($sformatf("vec%0d_keep", i), m_tkeep, vecs[i].exp_keep);
        check($sformatf("vec%0d_last", i), m_tlast, vecs[i].exp_last);
      end
    end
    s_tvalid = 1'b0;
    @(posedge clk); #1;

    // ---- reset mid-packet ----
    send(8'h21, 1'b0, "mid_21");
    send(8'h22, 1'b0, "mid_22");
    s_tvalid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst_s_ready", s_tready, 1'b0);
    check("mid_rst_m_valid", m_tvalid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send(8'h31, 1'b0, "mid_31");
    send(8'h32, 1'b0, "mid_32");
    send(8'h33, 1'b0, "mid_33");
    check("mid_no_early_word", m_tvalid, 1'b0);
    send(8'h34, 1'b1, "mid_34");
    check("mid_valid", m_tvalid, 1'b1);
    check("mid_data",  m_tdata,  32'h34333231);
    check("mid_keep",  m_tkeep,  4'hF);
    check("mid_last",  m_tlast,  1'b1);
    s_tvalid = 1'b0;
    @(posedge clk); #1;

    // ---- randomized stream with backpressure and one 7-cycle stall ----
    sent       = 0;
    cyc        = 0;
    stall_left = 0;
    stall_done = 1'b0;
    held_data  = '0;
    held_keep  = '0;
    held_last  = 1'b0;
    s_tdata    = DW'($urandom_range(0, 255));
    s_tlast    = ($urandom_range(0, 4) == 0);
    s_tvalid   = 1'b1;
    m_tready   = 1'b1;
    while (sent < N_RAND && cyc < 5000) begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      if (stall_left > 0) begin
        check("stall_s_ready", s_tready, 1'b0);
        check("stall_valid",   m_tvalid, 1'b1);
        check("stall_data",    m_tdata,  held_data);
        check("stall_keep",    m_tkeep,  held_keep);
        check("stall_last",    m_tlast,  held_last);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < N_RAND) begin
          s_tdata  = DW'($urandom_range(0, 255));
          s_tlast  = ($urandom_range(0, 4) == 0) || (sent == N_RAND - 1);
          s_tvalid = ($urandom_range(0, 7) != 0);
        end else begin
          s_tvalid = 1'b0;
        end
      end else if (!s_tvalid) begin
        s_tvalid = 1'b1;
      end
      if (stall_left > 0) stall_left--;
      if (stall_left == 0 && !stall_done && sent >= 20 && m_tvalid) begin
        stall_left = 7;
        stall_done = 1'b1;
        held_data  = m_tdata;
        held_keep  = m_tkeep;
        held_last  = m_tlast;
        m_tready   = 1'b0;
      end else if (stall_left > 0) begin
        m_tready = 1'b0;
      end else begin
        m_tready = ($urandom_range(0, 3) != 0);
      end
    end
    check("rand_all_beats_sent", sent, N_RAND);
    check("stall_exercised", stall_done, 1'b1);

    // Drain and confirm every expected word came out exactly once.
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_exp_empty",  exp_q.size(), 0);
    check("drain_part_empty", part_q.size(), 0);
    check("drain_m_valid",    m_tvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
